sram_arbiter: RTL

//   Shares the single external 1Mx16 SRAM between two requesters: port A (CPU side,
//   Mem2IO) and port B (program loader / debug port). Sequences each access (address

---
 rtl/sram_arb_pkg.sv | 21 ++
 rtl/sram_arbiter_rr_arb2.sv | 24 ++
 rtl/sram_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_arb_pkg;

  // Access sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Requester identity; also the encoding of the grant_b output
  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  // SRAM control strobes are active-low
  localparam logic STROBE_ACTIVE   = 1'b0;
  localparam logic STROBE_INACTIVE = 1'b1;

endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins outright; on contention
// the port that did not win last time is chosen.
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic    req_a_i,
  input  logic    req_b_i,
  input  req_id_t last_i,
  output req_id_t win_o,
  output logic    valid_o
);

  // Combinational pick, defaulting to A when only A (or nobody) asks
  always_comb begin
    valid_o = req_a_i | req_b_i;
    win_o   = REQ_A;
    if (req_a_i && req_b_i) begin
      win_o = (last_i == REQ_A) ? REQ_B : REQ_A;
    end else if (req_b_i) begin
      win_o = REQ_B;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one asynchronous SRAM between port A (CPU) and port B (loader/debug).
// Each access is IDLE -> ACCESS (WAIT_CYCLES cycles of strobes) -> DONE (ack).
// All SRAM strobes and the tristate enable are registered so they are glitch-free.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int AW          = 20,
  parameter int DW          = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          A_req,
  input  logic          A_we,
  input  logic [AW-1:0] A_addr,
  input  logic [DW-1:0] A_wdata,
  output logic          A_ack,
  output logic [DW-1:0] A_rdata,
  input  logic          B_req,
  input  logic          B_we,
  input  logic [AW-1:0] B_addr,
  input  logic [DW-1:0] B_wdata,
  output logic          B_ack,
  output logic [DW-1:0] B_rdata,
  output logic          busy,
  output logic          grant_b,
  output logic [AW-1:0] ADDR,
  output logic          CE,
  output logic          UB,
  output logic          LB,
  output logic          OE,
  output logic          WE,
  output logic [DW-1:0] Data_to_SRAM,
  input  logic [DW-1:0] Data_from_SRAM,
  output logic          tri_oe
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

  state_t        state_q;
  req_id_t       grant_q;
  logic [CNT_W-1:0] cnt_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] a_rdata_q, b_rdata_q;
  logic          a_ack_q, b_ack_q, busy_q, tri_oe_q;
  logic          ce_q, oe_q, we_n_q;

  req_id_t       arb_win_d;
  logic          arb_valid_d;
  logic          sel_we_d;
  logic [AW-1:0] sel_addr_d;
  logic [DW-1:0] sel_wdata_d;
  logic          cnt_last_d;

  rr_arb2 u_rr_arb2 (
    .req_a_i (A_req),
    .req_b_i (B_req),
    .last_i  (grant_q),
    .win_o   (arb_win_d),
    .valid_o (arb_valid_d)
  );

  // Steer the winning port's request fields toward the latch in IDLE
  always_comb begin
    sel_we_d    = (arb_win_d == REQ_B) ? B_we    : A_we;
    sel_addr_d  = (arb_win_d == REQ_B) ? B_addr  : A_addr;
    sel_wdata_d = (arb_win_d == REQ_B) ? B_wdata : A_wdata;
    cnt_last_d  = (cnt_q == CNT_W'(WAIT_CYCLES - 1));
  end

  // Access sequencer: latches the request, drives strobes, captures read data, pulses ack
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      grant_q   <= REQ_B;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      busy_q    <= 1'b0;
      tri_oe_q  <= 1'b0;
      ce_q      <= STROBE_INACTIVE;
      oe_q      <= STROBE_INACTIVE;
      we_n_q    <= STROBE_INACTIVE;
    end else begin
      case (state_q)
        IDLE: begin
          a_ack_q <= 1'b0;
          b_ack_q <= 1'b0;
          if (arb_valid_d) begin
            state_q  <= ACCESS;
            grant_q  <= arb_win_d;
            cnt_q    <= '0;
            we_q     <= sel_we_d;
            addr_q   <= sel_addr_d;
            busy_q   <= 1'b1;
            ce_q     <= STROBE_ACTIVE;
            oe_q     <= sel_we_d ? STROBE_INACTIVE : STROBE_ACTIVE;
            we_n_q   <= sel_we_d ? STROBE_ACTIVE : STROBE_INACTIVE;
            tri_oe_q <= sel_we_d;
            // Keep the previous write data on reads so the bus value stays stable
            if (sel_we_d) begin
              wdata_q <= sel_wdata_d;
            end
          end
        end
        ACCESS: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_last_d) begin
            state_q  <= DONE;
            ce_q     <= STROBE_INACTIVE;
            oe_q     <= STROBE_INACTIVE;
            we_n_q   <= STROBE_INACTIVE;
            tri_oe_q <= 1'b0;
            if (grant_q == REQ_B) begin
              b_ack_q <= 1'b1;
              if (!we_q) b_rdata_q <= Data_from_SRAM;
            end else begin
              a_ack_q <= 1'b1;
              if (!we_q) a_rdata_q <= Data_from_SRAM;
            end
          end
        end
        DONE: begin
          a_ack_q <= 1'b0;
          b_ack_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Byte lanes always enabled together with chip enable (16-bit accesses only)
  always_comb begin
    A_ack        = a_ack_q;
    B_ack        = b_ack_q;
    A_rdata      = a_rdata_q;
    B_rdata      = b_rdata_q;
    busy         = busy_q;
    grant_b      = (grant_q == REQ_B);
    ADDR         = addr_q;
    CE           = ce_q;
    UB           = ce_q;
    LB           = ce_q;
    OE           = oe_q;
    WE           = we_n_q;
    Data_to_SRAM = wdata_q;
    tri_oe       = tri_oe_q;
  end

endmodule
